// File: rtl/ocd_boot_sequencer_if.sv
// Host-command, OCD-port and run-status signals of the OCD boot sequencer, bundled for one port.
// slave = sequencer side, master = host/MCU side.
interface ocd_boot_sequencer_if #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 32,
  parameter int PC_BITS   = 32,
  parameter int CNT_BITS  = 32,
  parameter int WCNT_BITS = 16
);
  logic                 sync_reset;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [31:0]          cmd_addr;
  logic [DATA_BITS-1:0] cmd_data;
  logic                 cmd_last;
  logic [PC_BITS-1:0]   boot_addr;
  logic [CNT_BITS-1:0]  run_budget;
  logic                 ocd_write_enable;
  logic                 ocd_read_enable;
  logic [ADDR_BITS-1:0] ocd_rw_addr;
  logic [DATA_BITS-1:0] ocd_write_word;
  logic                 ocd_mem_enable_out;
  logic [DATA_BITS-1:0] ocd_mem_word_out;
  logic                 start;
  logic [PC_BITS-1:0]   start_address;
  logic                 processor_paused;
  logic                 busy;
  logic                 done;
  logic                 timeout;
  logic                 error;
  logic [WCNT_BITS-1:0] word_count;

  modport slave (
    input  sync_reset, cmd_valid, cmd_addr, cmd_data, cmd_last, boot_addr, run_budget,
           ocd_mem_enable_out, ocd_mem_word_out, processor_paused,
    output cmd_ready, ocd_write_enable, ocd_read_enable, ocd_rw_addr, ocd_write_word,
           start, start_address, busy, done, timeout, error, word_count
  );

  modport master (
    output sync_reset, cmd_valid, cmd_addr, cmd_data, cmd_last, boot_addr, run_budget,
           ocd_mem_enable_out, ocd_mem_word_out, processor_paused,
    input  cmd_ready, ocd_write_enable, ocd_read_enable, ocd_rw_addr, ocd_write_word,
           start, start_address, busy, done, timeout, error, word_count
  );
endinterface

// File: rtl/ocd_boot_sequencer.sv
// Loads an image through the MCU OCD port, then starts the core and supervises the run until pause or budget expiry.
// Optional OCD_READBACK_VERIFY_EN: read back and compare every written word before accepting the next.
module ocd_boot_sequencer #(
  parameter int ADDR_BITS       = 16,
  parameter int DATA_BITS       = 32,
  parameter int PC_BITS         = 32,
  parameter int CNT_BITS        = 32,
  parameter int WCNT_BITS       = 16,
  parameter int VERIFY_WAIT_MAX = 8
) (
  input logic                 clk,
  input logic                 reset_n,
  ocd_boot_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_BOOT, S_RUN, S_DONE, S_FAIL
`ifdef OCD_READBACK_VERIFY_EN
    , S_VERIFY
`endif
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_timeout_hit;
  logic                 w_hs;
  logic                 w_misalign;

  logic                 r_ready;
  logic                 r_wr_en;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_wdat;
  logic                 r_last;
  logic [PC_BITS-1:0]   r_boot;
  logic [PC_BITS-1:0]   r_start_addr;
  logic [WCNT_BITS-1:0] r_wcnt;
  logic [CNT_BITS-1:0]  r_cnt;
  logic                 r_done;
  logic                 r_timeout;
  logic                 r_error;

  assign w_hs       = bus.cmd_valid & r_ready;
  assign w_misalign = |bus.cmd_addr[1:0];

`ifdef OCD_READBACK_VERIFY_EN
  localparam int VW_BITS = $clog2(VERIFY_WAIT_MAX + 1);
  logic               r_rd_en;
  logic               r_rd_pend;
  logic [VW_BITS-1:0] r_vwait;
  logic               w_unused;
  assign w_unused = ^bus.cmd_addr;
`else
  logic w_unused;
  assign w_unused = ^{bus.cmd_addr, bus.ocd_mem_enable_out, bus.ocd_mem_word_out};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_hs) begin
          if (w_misalign) w_state_nxt = S_FAIL;
`ifdef OCD_READBACK_VERIFY_EN
          else            w_state_nxt = S_VERIFY;
`else
          else            w_state_nxt = S_LOAD;
`endif
        end else if (r_wr_en && r_last) begin
          w_state_nxt = S_BOOT;
        end
      end
`ifdef OCD_READBACK_VERIFY_EN
      S_VERIFY: begin
        if (r_rd_pend) begin
          if (bus.ocd_mem_enable_out) begin
            if (bus.ocd_mem_word_out == r_wdat) w_state_nxt = r_last ? S_BOOT : S_LOAD;
            else                                w_state_nxt = S_FAIL;
          end else if (r_vwait == VW_BITS'(VERIFY_WAIT_MAX - 1)) begin
            w_state_nxt = S_FAIL;
          end
        end
      end
`endif
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN: begin
        // the core may still report a stale pause for its first cycles out of reset
        if (bus.processor_paused && r_cnt >= CNT_BITS'(2)) begin
          w_state_nxt = S_DONE;
        end else if (bus.run_budget != '0 && r_cnt >= bus.run_budget - CNT_BITS'(1)) begin
          w_state_nxt   = S_DONE;
          w_timeout_hit = 1'b1;
        end
      end
      default: w_state_nxt = r_state;
    endcase
    if (bus.sync_reset) begin
      w_state_nxt   = S_IDLE;
      w_timeout_hit = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_addr       <= '0;
      r_wdat       <= '0;
      r_last       <= 1'b0;
      r_boot       <= '0;
      r_start_addr <= '0;
      r_wcnt       <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_error      <= 1'b0;
    end else if (bus.sync_reset) begin
      r_ready      <= 1'b1;
      r_wr_en      <= 1'b0;
      r_addr       <= '0;
      r_wdat       <= '0;
      r_last       <= 1'b0;
      r_boot       <= '0;
      r_start_addr <= '0;
      r_wcnt       <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      // no more commands are taken once the final word has been handed over
      r_ready <= (w_state_nxt == S_IDLE || w_state_nxt == S_LOAD) && !(w_hs && bus.cmd_last);
      r_wr_en <= w_hs && !w_misalign;
      if (w_hs && !w_misalign) begin
        r_addr <= bus.cmd_addr[ADDR_BITS+1:2];
        r_wdat <= bus.cmd_data;
        r_last <= bus.cmd_last;
        if (bus.cmd_last) r_boot <= bus.boot_addr;
      end
      if (r_wr_en && r_wcnt != '1) r_wcnt <= r_wcnt + WCNT_BITS'(1);
      if (w_state_nxt == S_BOOT && r_state != S_BOOT) r_start_addr <= r_boot;
      r_cnt <= (r_state == S_BOOT || r_state == S_RUN) ? r_cnt + CNT_BITS'(1) : '0;
      if (r_state == S_RUN && w_state_nxt == S_DONE) begin
        r_done    <= 1'b1;
        r_timeout <= w_timeout_hit;
      end
      if (w_state_nxt == S_FAIL && r_state != S_FAIL) r_error <= 1'b1;
    end
  end

`ifdef OCD_READBACK_VERIFY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_en   <= 1'b0;
      r_rd_pend <= 1'b0;
      r_vwait   <= '0;
    end else if (bus.sync_reset) begin
      r_rd_en   <= 1'b0;
      r_rd_pend <= 1'b0;
      r_vwait   <= '0;
    end else begin
      // read strobe follows the write strobe so the two never overlap
      r_rd_en   <= r_wr_en && r_state == S_VERIFY;
      r_rd_pend <= (r_rd_en || r_rd_pend) && w_state_nxt == S_VERIFY;
      r_vwait   <= r_rd_pend ? r_vwait + VW_BITS'(1) : '0;
    end
  end
  assign bus.ocd_read_enable = r_rd_en;
`else
  assign bus.ocd_read_enable = 1'b0;
`endif

  assign bus.cmd_ready        = r_ready;
  assign bus.ocd_write_enable = r_wr_en;
  assign bus.ocd_rw_addr      = r_addr;
  assign bus.ocd_write_word   = r_wdat;
  assign bus.start            = (r_state == S_BOOT) || (r_state == S_RUN);
  assign bus.start_address    = r_start_addr;
  assign bus.busy             = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_FAIL);
  assign bus.done             = r_done;
  assign bus.timeout          = r_timeout;
  assign bus.error            = r_error;
  assign bus.word_count       = r_wcnt;

endmodule

// File: tb/tb_ocd_boot_sequencer.sv
// Directed plus randomized bench for ocd_boot_sequencer; expected OCD writes, boot address and run outcome
// come from a transaction-level model of the load/run rules.
module tb_ocd_boot_sequencer;
  localparam int AB = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  ocd_boot_sequencer_if #(.ADDR_BITS(AB)) bus ();

  ocd_boot_sequencer #(.ADDR_BITS(AB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int rd_seen = 0;
  int start_ever = 0;
  logic [AB+31:0] got_q[$];
  logic [AB+31:0] exp_q[$];

  // memory model behind the OCD port; corrupt forces a bad readback
  bit             corrupt = 1'b0;
  logic [31:0]    mem_model [logic [AB-1:0]];
  logic [AB-1:0]  rd_addr;
  int             rd_cnt = 0;

  always @(negedge clk) begin
    if (bus.ocd_write_enable) got_q.push_back({bus.ocd_rw_addr, bus.ocd_write_word});
    if (bus.ocd_write_enable && bus.ocd_read_enable) overlap++;
    if (bus.ocd_read_enable) rd_seen++;
    if (bus.start) start_ever++;
    bus.ocd_mem_enable_out = 1'b0;
    bus.ocd_mem_word_out   = '0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        bus.ocd_mem_enable_out = 1'b1;
        bus.ocd_mem_word_out   = corrupt ? 32'hDEADBEEF : mem_model[rd_addr];
      end
    end
    if (bus.ocd_write_enable) mem_model[bus.ocd_rw_addr] = bus.ocd_write_word;
    if (bus.ocd_read_enable) begin
      rd_addr = bus.ocd_rw_addr;
      rd_cnt  = 2;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] d, input bit last,
                           input logic [31:0] boot);
    int w;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    bus.cmd_last  = last;
    bus.boot_addr = boot;
    w = 0;
    while (!bus.cmd_ready && w < 64) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_wait", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_last  = 1'b0;
  endtask

  task automatic do_sync_reset();
    bus.sync_reset = 1'b1;
    @(negedge clk);
    bus.sync_reset = 1'b0;
    chk("sr_done", bus.done, 0);
    chk("sr_timeout", bus.timeout, 0);
    chk("sr_error", bus.error, 0);
    chk("sr_busy", bus.busy, 0);
    chk("sr_start", bus.start, 0);
    chk("sr_word_count", bus.word_count, 0);
    chk("sr_cmd_ready", bus.cmd_ready, 1);
  endtask

  // p < 0: pause never raised; otherwise pause is high from run cycle p onward (cycle 0 = start rising)
  task automatic load_and_run(input int n, input logic [31:0] base, input logic [31:0] boot,
                              input int budget, input int p, input bit fixed_data);
    logic [31:0] a;
    logic [31:0] d;
    int ok, t, exp_t, pd, bd, start_cycles;
    bit exp_to;
    got_q.delete();
    exp_q.delete();
    bus.run_budget = 32'(budget);
    for (int i = 0; i < n; i++) begin
      a = base + 32'(4 * i);
      d = fixed_data ? 32'h0000_0013 : $urandom;
      exp_q.push_back({a[AB+1:2], d});
      send_word(a, d, (i == n - 1), boot);
    end
    ok = 0;
    for (int i = 0; i < 128; i++) begin
      if (bus.start) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("start_seen", ok, 1);
    chk("write_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk("write_addr_data", got_q[i], exp_q[i]);
    chk("word_count", bus.word_count, n);
    chk("start_address", bus.start_address, boot);
    chk("busy_boot", bus.busy, 1);

    pd = (p >= 0) ? ((p > 2 ? p : 2) + 1) : (1 << 30);
    bd = (budget != 0) ? budget : (1 << 30);
    exp_t  = (pd <= bd) ? pd : bd;
    exp_to = (bd < pd);
    t = 0;
    start_cycles = 0;
    bus.processor_paused = (p == 0);
    while (t < 400) begin
      if (bus.start) start_cycles++;
      @(negedge clk);
      t++;
      if (bus.done) break;
      bus.processor_paused = (p >= 0 && t >= p);
    end
    chk("done_cycle", t, exp_t);
    chk("timeout", bus.timeout, exp_to);
    chk("start_held", start_cycles, exp_t);
    chk("start_low_done", bus.start, 0);
    chk("error_run", bus.error, 0);
    bus.processor_paused = 1'b0;

    got_q.delete();
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = base;
    tick(4);
    bus.cmd_valid = 1'b0;
    chk("done_hold", bus.done, 1);
    chk("timeout_hold", bus.timeout, exp_to);
    chk("ready_in_done", bus.cmd_ready, 0);
    chk("ignored_cmd_writes", got_q.size(), 0);
    chk("word_count_hold", bus.word_count, n);
    do_sync_reset();
  endtask

  initial begin
    int n, budget, p;
    logic [31:0] base, boot;
    bus.sync_reset       = 1'b0;
    bus.cmd_valid        = 1'b0;
    bus.cmd_addr         = '0;
    bus.cmd_data         = '0;
    bus.cmd_last         = 1'b0;
    bus.boot_addr        = '0;
    bus.run_budget       = '0;
    bus.processor_paused = 1'b0;

    #2;
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_write", bus.ocd_write_enable, 0);
    chk("rst_start", bus.start, 0);
    chk("rst_flags", {bus.busy, bus.done, bus.timeout, bus.error}, 0);
    chk("rst_word_count", bus.word_count, 0);
    tick(3);
    reset_n = 1'b1;
    tick(2);
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    chk("idle_busy", bus.busy, 0);

    // four NOPs, pause at cycle 10 well inside the budget
    load_and_run(4, 32'h8000_0000, 32'h8000_0000, 2000, 10, 1'b1);
    // budget expiry with no pause
    load_and_run(2, 32'h8000_1000, 32'h8000_1000, 5, -1, 1'b0);
    // stale pause present while the core leaves reset
    load_and_run(1, 32'h8000_2000, 32'h8000_0100, 1000, 0, 1'b0);
    // pause and budget expiry decided in the same cycle
    load_and_run(3, 32'h8000_3000, 32'h8000_0200, 7, 6, 1'b0);

    for (int it = 0; it < 6; it++) begin
      n      = $urandom_range(1, 6);
      base   = 32'h8000_0000 | ($urandom_range(0, 4095) << 2);
      boot   = $urandom & 32'hFFFF_FFFC;
      budget = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 40);
      p      = (budget == 0) ? $urandom_range(0, 30)
             : (($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 40));
      load_and_run(n, base, boot, budget, p, 1'b0);
    end

    // misaligned first word: nothing written, sticky FAIL until sync_reset
    got_q.delete();
    send_word(32'h8000_0002, 32'h0000_0013, 1'b0, 32'h8000_0000);
    tick(3);
    chk("mis_writes", got_q.size(), 0);
    chk("mis_error", bus.error, 1);
    chk("mis_ready", bus.cmd_ready, 0);
    chk("mis_busy", bus.busy, 0);
    tick(5);
    chk("mis_ready_held", bus.cmd_ready, 0);
    chk("mis_error_held", bus.error, 1);
    do_sync_reset();

    // misaligned after two good words
    got_q.delete();
    send_word(32'h8000_0100, 32'h1111_1111, 1'b0, 32'h0);
    send_word(32'h8000_0104, 32'h2222_2222, 1'b0, 32'h0);
    send_word(32'h8000_0109, 32'h3333_3333, 1'b1, 32'h0);
    tick(4);
    chk("mis2_writes", got_q.size(), 2);
    chk("mis2_error", bus.error, 1);
    chk("mis2_start", bus.start, 0);
    chk("mis2_word_count", bus.word_count, 2);
    do_sync_reset();

    // reset_n asserted during the third write of an eight-word load
    got_q.delete();
    for (int i = 0; i < 3; i++) send_word(32'h8000_0000 + 32'(4 * i), $urandom, 1'b0, 32'h0);
    chk("abort_third_strobe", bus.ocd_write_enable, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_write", bus.ocd_write_enable, 0);
    chk("abort_ready", bus.cmd_ready, 0);
    chk("abort_word_count", bus.word_count, 0);
    chk("abort_addr_data", {bus.ocd_rw_addr, bus.ocd_write_word}, 0);
    chk("abort_flags", {bus.busy, bus.start, bus.done, bus.error}, 0);
    tick(2);
    reset_n = 1'b1;
    got_q.delete();
    tick(10);
    chk("abort_no_strobes", got_q.size(), 0);
    chk("abort_ready_after", bus.cmd_ready, 1);
    chk("abort_busy_after", bus.busy, 0);
    load_and_run(2, 32'h8000_0400, 32'h8000_0400, 20, 4, 1'b0);

`ifdef OCD_READBACK_VERIFY_EN
    corrupt = 1'b1;
    start_ever = 0;
    send_word(32'h8000_0000, 32'h0000_0013, 1'b1, 32'h8000_0000);
    tick(15);
    chk("vfy_error", bus.error, 1);
    chk("vfy_start_never", start_ever, 0);
    chk("vfy_busy", bus.busy, 0);
    corrupt = 1'b0;
    do_sync_reset();
`else
    chk("no_read_strobes", rd_seen, 0);
`endif
    chk("no_rw_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ocd_boot_sequencer.md
Name: ocd_boot_sequencer

Overview:
- Sequences the MCU's on-chip-debugger (OCD) port for program bring-up.
- Accepts a stream of (address, word) load commands from a host-side source (UART loader or bench) and issues OCD memory writes.
- After the last word, asserts start with the boot address and supervises the run until processor_paused is seen or a cycle budget expires.
- Sits between the host command source and PulseRain_RV2T_MCU's ocd_*/start ports.

Parameters:
ADDR_BITS, `MEM_ADDR_BITS, width of the OCD word address (ocd_rw_addr)
DATA_BITS, `XLEN, width of the OCD data word
PC_BITS, `PC_BITWIDTH, width of start_address
CNT_BITS, 32, width of the run-cycle counter and budget
WCNT_BITS, 16, width of the loaded-word counter
VERIFY_WAIT_MAX, 8, cycles allowed for ocd_mem_enable_out after a readback request

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sync_reset  in  1  synchronous return to IDLE, active high
cmd_valid  in  1  load command valid
cmd_ready  out  1  block accepts command this cycle
cmd_addr  in  32  byte address of word; bits[1:0] must be 0
cmd_data  in  DATA_BITS  word to store
cmd_last  in  1  final word of image
boot_addr  in  PC_BITS  entry point, sampled on last handshake
run_budget  in  CNT_BITS  max run cycles; 0 = unlimited
ocd_write_enable  out  1  OCD write strobe
ocd_read_enable  out  1  OCD read strobe
ocd_rw_addr  out  ADDR_BITS  OCD word address
ocd_write_word  out  DATA_BITS  OCD write data
ocd_mem_enable_out  in  1  OCD read data valid
ocd_mem_word_out  in  DATA_BITS  OCD read data
start  out  1  MCU run request
start_address  out  PC_BITS  MCU entry point
processor_paused  in  1  MCU paused indication
busy  out  1  state not IDLE/DONE/FAIL
done  out  1  run finished (pause or timeout)
timeout  out  1  run ended by budget expiry
error  out  1  misaligned address or verify mismatch/timeout
word_count  out  WCNT_BITS  words written since IDLE

Behaviour:
- Clock/reset: one clock, clk; reset_n is asynchronous and active-low. All outputs reset to 0, state = IDLE. sync_reset forces the same values on the next clk edge and has priority over every other event.
- States: IDLE, LOAD, VERIFY, BOOT, RUN, DONE, FAIL.
- IDLE/LOAD:
  - cmd_ready=1.
  - On a handshake, the next cycle drives ocd_write_enable=1 for exactly one cycle, with ocd_rw_addr=cmd_addr[ADDR_BITS+1:2] and ocd_write_word=cmd_data. Address and data are registered.
  - word_count increments on each write and saturates at all-ones.
  - A handshake in IDLE enters LOAD.
- Misaligned address: a handshake with cmd_addr[1:0]!=0 issues no write, sets error=1 and enters FAIL.
- cmd_last on a handshake: boot_addr is latched after that word's write (and verify, if enabled); the block then enters BOOT.
- BOOT (1 cycle): start=1, start_address=latched boot_addr; the run counter clears; enter RUN.
- RUN:
  - start stays 1 and the counter increments each cycle.
  - processor_paused=1 at counter>=2 (this masks the stale pause before the core leaves reset) enters DONE with done=1.
  - If run_budget!=0 and counter==run_budget-1, enter DONE with done=1 and timeout=1.
  - If pause and budget expiry occur in the same cycle, pause wins and timeout=0.
- DONE/FAIL: start=0, cmd_ready=0, status flags held until sync_reset or reset_n.
- Boundaries:
  - cmd_valid without cmd_ready must be ignored.
  - Reset mid-load aborts; no further OCD strobes.
  - ocd_read_enable and ocd_write_enable are never high together.

Optional Feature:
OCD_READBACK_VERIFY_EN:
- Defined:
  - After each write, enter VERIFY with cmd_ready=0.
  - Pulse ocd_read_enable for 1 cycle on the same address.
  - Wait up to VERIFY_WAIT_MAX cycles for ocd_mem_enable_out, then compare ocd_mem_word_out to the written word.
  - On a match, return to LOAD (or go to BOOT if the word was last).
  - On a mismatch or wait timeout, set error=1 and enter FAIL.
- Undefined: no VERIFY state, ocd_read_enable tied 0, cmd_ready=1 continuously in LOAD, sustained throughput of one word per clk.

Test Plan:
- Load 4 words at 0x80000000..0x8000000C (data 0x00000013), last on 4th, boot_addr=0x80000000 -> four 1-cycle ocd_write_enable pulses with ocd_rw_addr 0x0000..0x0003 (masked to ADDR_BITS), word_count=4, then start=1 with start_address=0x80000000.
- RUN with processor_paused raised at cycle 10, run_budget=2000 -> done=1, timeout=0, start=0 on the next cycle.
- run_budget=5 with processor_paused=0 -> done=1 and timeout=1 exactly 5 cycles after start rose.
- cmd_addr=0x80000002 -> no write strobe, error=1, state FAIL, cmd_ready=0 until sync_reset; sync_reset -> all flags 0 and cmd_ready=1.
- With OCD_READBACK_VERIFY_EN and a model returning 0xDEADBEEF for a written 0x00000013 -> error=1, FAIL, start never asserted; with a model returning the correct data, load completes at 1 word per (4 + read latency) cycles.
- Assert reset_n low during the 3rd write of an 8-word load -> all outputs 0 asynchronously; after release, no OCD strobes until a new cmd_valid.
